// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 32x32 register file. Two requesters (A = writeback,
// B = load/special-register update) share one write port through a registered
// two-way round-robin. The committed write is presented for exactly one cycle
// as a one-hot LOAD word line plus broadcast WDATA.
module rf_write_arbiter #(
  parameter bit R0_ZERO    = 1'b1,  // 1: writes to r0 are acked but never load
  parameter bit PRIO_RESET = 1'b0   // requester that wins the first conflict (0 = A, 1 = B)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        REQ_A,
  input  logic [4:0]  ADDR_A,
  input  logic [31:0] DATA_A,
  output logic        ACK_A,
  input  logic        REQ_B,
  input  logic [4:0]  ADDR_B,
  input  logic [31:0] DATA_B,
  output logic        ACK_B,
  output logic [31:0] LOAD,
  output logic [31:0] WDATA,
  output logic [4:0]  WADDR,
  output logic        GNT_B
);

  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic [31:0] load_q, load_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        gnt_b_q, gnt_b_d;
  // favour_b_q: B wins the next conflict (i.e. A was granted most recently)
  logic        favour_b_q, favour_b_d;

  logic        elig_a, elig_b;
  logic        win_a, win_b;
  logic [4:0]  sel_addr;

  // Eligibility, arbitration and next-state for the output registers
  always_comb begin
    // A requester that is acking this cycle sits out the next edge
    elig_a = REQ_A & ~ack_a_q;
    elig_b = REQ_B & ~ack_b_q;
    win_a  = elig_a & (~elig_b | ~favour_b_q);
    win_b  = elig_b & (~elig_a | favour_b_q);

    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    load_d     = '0;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    gnt_b_d    = gnt_b_q;
    favour_b_d = favour_b_q;
    sel_addr   = win_b ? ADDR_B : ADDR_A;

    if (!STALL && (win_a || win_b)) begin
      ack_a_d    = win_a;
      ack_b_d    = win_b;
      gnt_b_d    = win_b;
      favour_b_d = win_a;
      waddr_d    = sel_addr;
      wdata_d    = win_b ? DATA_B : DATA_A;
      if (!(R0_ZERO && (sel_addr == 5'd0))) begin
        load_d = 32'd1 << sel_addr;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      load_q     <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      gnt_b_q    <= 1'b0;
      favour_b_q <= PRIO_RESET;
    end else begin
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      load_q     <= load_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      gnt_b_q    <= gnt_b_d;
      favour_b_q <= favour_b_d;
    end
  end

  assign ACK_A = ack_a_q;
  assign ACK_B = ack_b_q;
  assign LOAD  = load_q;
  assign WDATA = wdata_q;
  assign WADDR = waddr_q;
  assign GNT_B = gnt_b_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench: two arbiter instances (R0_ZERO=1/PRIO A, R0_ZERO=0/PRIO B)
// share stimulus. A reference model turns each sampled edge into expected
// commits; a monitor pops them whenever a DUT acks.
module tb_rf_write_arbiter;

  logic        CLK = 1'b0;
  logic        RESET, STALL;
  logic        REQ_A, REQ_B;
  logic [4:0]  ADDR_A, ADDR_B;
  logic [31:0] DATA_A, DATA_B;

  logic [1:0]  ack_a, ack_b, gnt_b;
  logic [31:0] load  [2];
  logic [31:0] wdata [2];
  logic [4:0]  waddr [2];

  always #5 CLK = ~CLK;

  rf_write_arbiter #(.R0_ZERO(1'b1), .PRIO_RESET(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .REQ_A(REQ_A), .ADDR_A(ADDR_A), .DATA_A(DATA_A), .ACK_A(ack_a[0]),
    .REQ_B(REQ_B), .ADDR_B(ADDR_B), .DATA_B(DATA_B), .ACK_B(ack_b[0]),
    .LOAD(load[0]), .WDATA(wdata[0]), .WADDR(waddr[0]), .GNT_B(gnt_b[0])
  );

  rf_write_arbiter #(.R0_ZERO(1'b0), .PRIO_RESET(1'b1)) dut1 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .REQ_A(REQ_A), .ADDR_A(ADDR_A), .DATA_A(DATA_A), .ACK_A(ack_a[1]),
    .REQ_B(REQ_B), .ADDR_B(ADDR_B), .DATA_B(DATA_B), .ACK_B(ack_b[1]),
    .LOAD(load[1]), .WDATA(wdata[1]), .WADDR(waddr[1]), .GNT_B(gnt_b[1])
  );

  typedef struct {
    int          cyc;
    logic        b;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] load;
  } exp_t;

  exp_t exp_q [2][$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit started = 1'b0;

  // Reference model state, per instance
  bit          m_ack_a [2];
  bit          m_ack_b [2];
  bit          m_last_b [2];   // most recent grant went to B
  logic [31:0] m_wdata [2];
  logic [4:0]  m_waddr [2];

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  // Reference model: evaluate the arbitration rules at every edge
  always @(posedge CLK) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!RESET) begin
        started     = 1'b1;
        m_ack_a[d]  = 1'b0;
        m_ack_b[d]  = 1'b0;
        m_wdata[d]  = '0;
        m_waddr[d]  = '0;
        // PRIO A (d=0) means B counts as most recently granted
        m_last_b[d] = (d == 0);
      end else begin
        bit ea, eb, pick_b;
        exp_t e;
        ea = REQ_A && !m_ack_a[d];
        eb = REQ_B && !m_ack_b[d];
        m_ack_a[d] = 1'b0;
        m_ack_b[d] = 1'b0;
        if (!STALL && (ea || eb)) begin
          pick_b = eb && (!ea || !m_last_b[d]);
          e.cyc  = cyc;
          e.b    = pick_b;
          e.addr = pick_b ? ADDR_B : ADDR_A;
          e.data = pick_b ? DATA_B : DATA_A;
          e.load = (d == 0 && e.addr == 5'd0) ? 32'd0 : (32'd1 << e.addr);
          exp_q[d].push_back(e);
          m_last_b[d] = pick_b;
          m_ack_a[d]  = !pick_b;
          m_ack_b[d]  = pick_b;
          m_wdata[d]  = e.data;
          m_waddr[d]  = e.addr;
        end
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the scoreboard
  always @(negedge CLK) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        chk("ack_exclusive", d, 32'(ack_a[d] & ack_b[d]), 32'd0);
        if (ack_a[d] || ack_b[d]) begin
          if (exp_q[d].size() == 0) begin
            chk("spurious_ack", d, {30'd0, ack_a[d], ack_b[d]}, 32'd0);
          end else begin
            e = exp_q[d].pop_front();
            chk("commit_cycle", d, cyc, e.cyc);
            chk("ack_b", d, 32'(ack_b[d]), 32'(e.b));
            chk("gnt_b", d, 32'(gnt_b[d]), 32'(e.b));
            chk("waddr", d, 32'(waddr[d]), 32'(e.addr));
            chk("wdata", d, wdata[d], e.data);
            chk("load", d, load[d], e.load);
          end
        end else begin
          chk("idle_load", d, load[d], 32'd0);
          chk("hold_wdata", d, wdata[d], m_wdata[d]);
          chk("hold_waddr", d, 32'(waddr[d]), 32'(m_waddr[d]));
          if (exp_q[d].size() != 0 && exp_q[d][0].cyc <= cyc) begin
            chk("missed_commit", d, 32'(ack_a[d] | ack_b[d]), 32'd1);
            void'(exp_q[d].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_a(input logic req, input logic [4:0] a, input logic [31:0] dt);
    REQ_A = req; ADDR_A = a; DATA_A = dt;
  endtask

  task automatic set_b(input logic req, input logic [4:0] a, input logic [31:0] dt);
    REQ_B = req; ADDR_B = a; DATA_B = dt;
  endtask

  initial begin
    RESET = 1'b0; STALL = 1'b0;
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    // Single A write to r5
    RESET = 1'b1;
    set_a(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_a(1'b0, 5'd0, 32'd0);
    repeat (3) tick();

    // Both held from reset: alternating commits
    RESET = 1'b0;
    set_a(1'b1, 5'd1, 32'h1111_1111);
    set_b(1'b1, 5'd2, 32'h2222_2222);
    tick();
    RESET = 1'b1;
    repeat (8) tick();

    // Only B held: one write every other cycle
    set_a(1'b0, 5'd0, 32'd0);
    repeat (6) tick();
    set_b(1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    // Write to r0 (instance 0 suppresses LOAD, instance 1 asserts LOAD[0])
    set_a(1'b1, 5'd0, 32'hCAFE_0000);
    tick();
    set_a(1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    // Stall with both requesting, then release
    STALL = 1'b1;
    set_a(1'b1, 5'd3, 32'hAAAA_0003);
    set_b(1'b1, 5'd4, 32'hBBBB_0004);
    repeat (3) tick();
    STALL = 1'b0;
    repeat (4) tick();
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    // Reset on the granting edge, then reset while ACK is high
    set_a(1'b1, 5'd7, 32'h7777_7777);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    set_a(1'b0, 5'd0, 32'd0);
    repeat (3) tick();

    // Randomised traffic: requesters follow the handshake of instance 0
    for (int n = 0; n < 1500; n++) begin
      RESET = ($urandom_range(0, 79) != 0);
      STALL = ($urandom_range(0, 7) == 0);
      if (!REQ_A || ack_a[0]) begin
        if ($urandom_range(0, 3) != 0) set_a(1'b1, 5'($urandom), $urandom);
        else REQ_A = 1'b0;
      end else if ($urandom_range(0, 23) == 0) begin
        REQ_A = 1'b0;
      end
      if (!REQ_B || ack_b[0]) begin
        if ($urandom_range(0, 3) != 0) set_b(1'b1, 5'($urandom), $urandom);
        else REQ_B = 1'b0;
      end else if ($urandom_range(0, 23) == 0) begin
        REQ_B = 1'b0;
      end
      tick();
    end

    RESET = 1'b1; STALL = 1'b0;
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    repeat (4) tick();
    @(negedge CLK);
    for (int d = 0; d < 2; d++) chk("queue_drained", d, 32'(exp_q[d].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
